quad_gather: RTL and testbench

QUAD_GATHER -- requirements
Module: quad_gather

---
 rtl/product_pkg.sv | 27 ++
 rtl/quad_gather.sv | 141 ++++++++++++++
 tb/tb_quad_gather.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/product_pkg.sv
// Shared product-path types: gather stage state/pad defaults and product stage types.
package product_pkg;

    // Lanes carried by one bundle from the gather stage into the product stage.
    localparam int unsigned PRODUCT_LANES = 4;

    // Fill value for bundle slots above the last real word.
    localparam int unsigned GATHER_DEFAULT_PAD = 1;

    // Gather stage: assembling words, or holding a finished bundle behind a busy output bank.
    typedef enum logic {
        G_FILL = 1'b0,
        G_WAIT = 1'b1
    } gather_state_t;

    // Product stage handshake state.
    typedef enum logic {
        P_IDLE = 1'b0,
        P_BUSY = 1'b1
    } product_state_t;

    // Real-word count of a bundle that completes with the given slot index.
    function automatic logic [2:0] gather_words(input logic [1:0] slot);
        return {1'b0, slot} + 3'd1;
    endfunction

endpackage

// File: rtl/quad_gather.sv
// Gathers up to four serial words into one parallel bundle with a one-deep skid
// (the assembly bank) in front of the output bank.
module quad_gather
    import product_pkg::*;
#(
    parameter int unsigned    W   = 32,
    parameter logic [W-1:0]   PAD = W'(GATHER_DEFAULT_PAD)
) (
    input  logic          i_clk,
    input  logic          i_reset_n,
    input  logic          i_in_valid,
    output logic          o_in_ready,
    input  logic [W-1:0]  i_in_data,
    input  logic          i_in_last,
    output logic          o_out_valid,
    output logic [W-1:0]  o_data0,
    output logic [W-1:0]  o_data1,
    output logic [W-1:0]  o_data2,
    output logic [W-1:0]  o_data3,
    output logic [2:0]    o_out_words,
    input  logic          i_out_ready
);

    gather_state_t state;
    gather_state_t state_next;

    logic [1:0]   cnt;
    logic [W-1:0] asm_bank [PRODUCT_LANES];
    logic [2:0]   held_words;

    logic [W-1:0] bundle [PRODUCT_LANES];
    logic [2:0]   bundle_words;

    logic accept;
    logic complete;
    logic out_free;

    // Handshake decode: ready is a pure function of state.
    always_comb begin
        o_in_ready = (state == G_FILL);
        accept     = i_in_valid & o_in_ready;
        complete   = accept & ((cnt == 2'd3) | i_in_last);
        out_free   = ~o_out_valid | i_out_ready;
    end

    // Bundle as it looks on the completing accept: stored words, the incoming word, then pad.
    always_comb begin
        bundle_words = gather_words(cnt);
        for (int unsigned i = 0; i < PRODUCT_LANES; i++) begin
            if (i < 32'(cnt)) begin
                bundle[i] = asm_bank[i];
            end else if (i == 32'(cnt)) begin
                bundle[i] = i_in_data;
            end else begin
                bundle[i] = PAD;
            end
        end
    end

    // State register.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state <= G_FILL;
        end else begin
            state <= state_next;
        end
    end

    // Next state: park in G_WAIT when a bundle completes behind a busy output bank.
    always_comb begin
        state_next = state;
        case (state)
            G_FILL: begin
                if (complete && !out_free) begin
                    state_next = G_WAIT;
                end
            end
            G_WAIT: begin
                if (out_free) begin
                    state_next = G_FILL;
                end
            end
            default: state_next = G_FILL;
        endcase
    end

    // Slot counter and assembly bank; a blocked bundle is captured whole, pad included.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            cnt        <= '0;
            held_words <= '0;
            for (int unsigned i = 0; i < PRODUCT_LANES; i++) begin
                asm_bank[i] <= '0;
            end
        end else if (accept) begin
            if (complete) begin
                cnt <= '0;
                if (!out_free) begin
                    held_words <= bundle_words;
                    for (int unsigned i = 0; i < PRODUCT_LANES; i++) begin
                        asm_bank[i] <= bundle[i];
                    end
                end
            end else begin
                asm_bank[cnt] <= i_in_data;
                cnt           <= cnt + 2'd1;
            end
        end
    end

    // Output bank: loads from the held bundle first, else from a completing accept.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            o_out_valid <= 1'b0;
            o_out_words <= '0;
            o_data0     <= '0;
            o_data1     <= '0;
            o_data2     <= '0;
            o_data3     <= '0;
        end else if (state == G_WAIT) begin
            if (out_free) begin
                o_out_valid <= 1'b1;
                o_out_words <= held_words;
                o_data0     <= asm_bank[0];
                o_data1     <= asm_bank[1];
                o_data2     <= asm_bank[2];
                o_data3     <= asm_bank[3];
            end
        end else if (complete && out_free) begin
            o_out_valid <= 1'b1;
            o_out_words <= bundle_words;
            o_data0     <= bundle[0];
            o_data1     <= bundle[1];
            o_data2     <= bundle[2];
            o_data3     <= bundle[3];
        end else if (o_out_valid && i_out_ready) begin
            o_out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_quad_gather.sv
// Scoreboard bench for quad_gather: directed word streams, monitor compares each transferred bundle.
module tb_quad_gather;

    localparam int unsigned W = 32;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_last = 1'b0;
    logic [W-1:0]  in_data = '0;
    logic          out_ready = 1'b0;
    logic          in_ready;
    logic          out_valid;
    logic [W-1:0]  d0, d1, d2, d3;
    logic [2:0]    out_words;

    typedef struct packed {
        logic [31:0] d0;
        logic [31:0] d1;
        logic [31:0] d2;
        logic [31:0] d3;
        logic [2:0]  words;
    } bundle_t;

    bundle_t exp_q[$];
    int tests = 0;
    int fails = 0;

    quad_gather #(.W(W), .PAD(32'd1)) dut (
        .i_clk       (clk),
        .i_reset_n   (reset_n),
        .i_in_valid  (in_valid),
        .o_in_ready  (in_ready),
        .i_in_data   (in_data),
        .i_in_last   (in_last),
        .o_out_valid (out_valid),
        .o_data0     (d0),
        .o_data1     (d1),
        .o_data2     (d2),
        .o_data3     (d3),
        .o_out_words (out_words),
        .i_out_ready (out_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic bundle_t mk(input logic [31:0] a, input logic [31:0] b,
                                   input logic [31:0] c, input logic [31:0] d,
                                   input logic [2:0] n);
        bundle_t r;
        r.d0 = a; r.d1 = b; r.d2 = c; r.d3 = d; r.words = n;
        return r;
    endfunction

    // Offer one word until accepted; cycles reports how many edges it took.
    task automatic send(input logic [31:0] w, input logic last, output int cycles);
        logic acc;
        acc      = 1'b0;
        cycles   = 0;
        in_valid = 1'b1;
        in_data  = w;
        in_last  = last;
        for (int i = 0; i < 50 && !acc; i++) begin
            acc = in_ready;
            @(posedge clk);
            #1;
            cycles++;
        end
        if (!acc) begin
            tests++;
            fails++;
            $display("FAIL send_timeout: word %0h never accepted, required accept within 50 cycles", w);
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    // Monitor: pops on each transfer and checks stability of stalled bundles.
    initial begin
        logic    stalled;
        bundle_t held;
        bundle_t e;
        stalled = 1'b0;
        held    = '0;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                stalled = 1'b0;
            end else begin
                if (stalled) begin
                    check("stall_valid", 32'(out_valid), 32'd1);
                    check("stall_d0", d0, held.d0);
                    check("stall_d3", d3, held.d3);
                    check("stall_words", 32'(out_words), 32'(held.words));
                end
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) begin
                        tests++;
                        fails++;
                        $display("FAIL unexpected_bundle: got d0=%0h d1=%0h words=%0d, required no bundle",
                                 d0, d1, out_words);
                    end else begin
                        e = exp_q.pop_front();
                        check("bundle_d0", d0, e.d0);
                        check("bundle_d1", d1, e.d1);
                        check("bundle_d2", d2, e.d2);
                        check("bundle_d3", d3, e.d3);
                        check("bundle_words", 32'(out_words), 32'(e.words));
                    end
                end
                stalled = out_valid && !out_ready;
                held    = mk(d0, d1, d2, d3, out_words);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        int total;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_d0", d0, 32'd0);
        check("rst_d3", d3, 32'd0);
        check("rst_words", 32'(out_words), 32'd0);
        reset_n   = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;

        // Full bundle, one-cycle latency
        exp_q.push_back(mk(2, 3, 4, 5, 4));
        send(2, 0, cyc);
        send(3, 0, cyc);
        send(4, 0, cyc);
        check("lat_valid_before", 32'(out_valid), 32'd0);
        send(5, 0, cyc);
        check("lat_valid_after", 32'(out_valid), 32'd1);

        // Short bundles padded
        exp_q.push_back(mk(7, 9, 1, 1, 2));
        send(7, 0, cyc);
        send(9, 1, cyc);
        exp_q.push_back(mk(6, 1, 1, 1, 1));
        send(6, 1, cyc);

        // Sustained throughput
        exp_q.push_back(mk(100, 101, 102, 103, 4));
        exp_q.push_back(mk(104, 105, 106, 107, 4));
        exp_q.push_back(mk(108, 109, 110, 111, 4));
        total = 0;
        for (int i = 0; i < 12; i++) begin
            send(32'(100 + i), 0, cyc);
            total += cyc;
        end
        check("throughput_cycles", 32'(total), 32'd12);
        @(posedge clk);
        #1;

        // Backpressure: one presented, one held, next word blocked
        out_ready = 1'b0;
        exp_q.push_back(mk(1, 2, 3, 4, 4));
        exp_q.push_back(mk(5, 6, 7, 8, 4));
        exp_q.push_back(mk(9, 1, 1, 1, 1));
        for (int i = 1; i <= 8; i++) begin
            send(32'(i), 0, cyc);
        end
        check("wait_in_ready", 32'(in_ready), 32'd0);
        in_valid = 1'b1;
        in_data  = 9;
        in_last  = 1'b1;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        check("wait_in_ready_hold", 32'(in_ready), 32'd0);
        check("wait_present_d0", d0, 32'd1);
        check("wait_present_d1", d1, 32'd2);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("release_d0", d0, 32'd5);
        check("release_valid", 32'(out_valid), 32'd1);
        check("release_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        check("nine_d0", d0, 32'd9);
        check("nine_words", 32'(out_words), 32'd1);
        @(posedge clk);
        #1;

        // Reset mid-bundle discards partial words; accepts ignored in reset
        send(10, 0, cyc);
        send(11, 0, cyc);
        #2;
        reset_n  = 1'b0;
        in_valid = 1'b1;
        in_data  = 99;
        in_last  = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_in_ready", 32'(in_ready), 32'd1);
        check("midrst_d0", d0, 32'd0);
        in_valid = 1'b0;
        in_last  = 1'b0;
        reset_n  = 1'b1;
        @(posedge clk);
        #1;
        exp_q.push_back(mk(20, 21, 22, 23, 4));
        send(20, 0, cyc);
        send(21, 0, cyc);
        send(22, 0, cyc);
        send(23, 0, cyc);

        // Last on the fourth word is a single completion
        exp_q.push_back(mk(40, 41, 42, 43, 4));
        exp_q.push_back(mk(50, 1, 1, 1, 1));
        send(40, 0, cyc);
        send(41, 0, cyc);
        send(42, 0, cyc);
        send(43, 1, cyc);
        send(50, 1, cyc);

        for (int i = 0; i < 20 && exp_q.size() != 0; i++) begin
            @(posedge clk);
            #1;
        end
        repeat (2) @(posedge clk);
        #1;
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        check("final_valid", 32'(out_valid), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
